vend_sequencer: RTL and testbench

Sequencer between the coin acceptor, the vending FSM and the machine's actuators. It cleans raw coin-sense lines into single-cycle, mutually exclusive N/D/Q pulses for the FSM. It inhibits and rejects coins while a vend is in progress. It converts the FSM's one-cycle Dispense/Return outputs into a timed series of motor and hopper pulses, one actuator at a time.

---
 rtl/vend_pkg.sv | 26 ++
 rtl/vend_sequencer_if.sv | 32 +++
 rtl/pulse_timer.sv | 26 ++
 rtl/vend_sequencer.sv | 147 ++++++++++++++
 tb/tb_vend_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types for the vend sequencer: FSM states, forwarded coin codes and the count width.
package vend_pkg;

    localparam int unsigned CNT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOTOR,
        ST_NICKEL,
        ST_DIME,
        ST_GAP
    } state_e;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_NICKEL,
        COIN_DIME,
        COIN_QUARTER
    } coin_e;

    // Dimes owed: ret_dime counts 1, ret_two_dimes counts 2, and the total saturates at 2.
    function automatic logic [CNT_W-1:0] dime_count(input logic ret_dime, input logic ret_two_dimes);
        return ret_two_dimes ? CNT_W'(2) : CNT_W'(ret_dime);
    endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Signal bundle between the acceptor/FSM side (master) and the sequencer (slave).
interface vend_sequencer_if;
    logic coin_n;
    logic coin_d;
    logic coin_q;
    logic dispense;
    logic ret_nickel;
    logic ret_dime;
    logic ret_two_dimes;
    logic N;
    logic D;
    logic Q;
    logic coin_reject;
    logic coin_inhibit;
    logic motor_en;
    logic hopper_nickel;
    logic hopper_dime;
    logic busy;
    logic seq_err;

    modport master (
        output coin_n, coin_d, coin_q, dispense, ret_nickel, ret_dime, ret_two_dimes,
        input  N, D, Q, coin_reject, coin_inhibit, motor_en, hopper_nickel, hopper_dime,
               busy, seq_err
    );

    modport slave (
        input  coin_n, coin_d, coin_q, dispense, ret_nickel, ret_dime, ret_two_dimes,
        output N, D, Q, coin_reject, coin_inhibit, motor_en, hopper_nickel, hopper_dime,
               busy, seq_err
    );
endinterface

// File: rtl/pulse_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module pulse_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign expire = (r_cnt == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Coin edge cleaner plus vend FSM that plays out motor, nickel and dime pulses one at a time.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input logic             clk,
    input logic             rst,
    vend_sequencer_if.slave bus
);

    localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
    // The timer expires on its last count, so a phase of N cycles loads N-1.
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_nick;
    logic [CNT_W-1:0] w_nick_d;
    logic [CNT_W-1:0] r_dime;
    logic [CNT_W-1:0] w_dime_d;
    logic             r_err;
    logic             w_err_d;
    logic             w_busy;
    logic             w_load;
    logic [TMR_W-1:0] w_load_val;
    logic             w_expire;

    logic [2:0] r_coin_prev;
    logic [2:0] w_coin_lvl;
    logic [2:0] w_edge;
    logic       w_multi;
    logic       w_block;
    coin_e      r_coin;
    coin_e      w_coin_d;
    logic       r_reject;
    logic       w_reject_d;

    pulse_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .expire   (w_expire)
    );

    assign w_busy = (r_state != ST_IDLE);

    always_comb begin
        w_state_d  = r_state;
        w_nick_d   = r_nick;
        w_dime_d   = r_dime;
        w_err_d    = r_err;
        w_load     = 1'b0;
        w_load_val = PULSE_LOAD;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.dispense) begin
                    w_state_d = ST_MOTOR;
                    w_load    = 1'b1;
                    w_nick_d  = CNT_W'(bus.ret_nickel);
                    w_dime_d  = dime_count(bus.ret_dime, bus.ret_two_dimes);
                    if (bus.ret_dime && bus.ret_two_dimes) w_err_d = 1'b1;
                end
            end
            ST_MOTOR, ST_NICKEL, ST_DIME: begin
                if (w_expire) begin
                    w_state_d  = ST_GAP;
                    w_load     = 1'b1;
                    w_load_val = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (w_expire) begin
                    if (r_nick != '0) begin
                        w_state_d = ST_NICKEL;
                        w_nick_d  = r_nick - CNT_W'(1);
                        w_load    = 1'b1;
                    end else if (r_dime != '0) begin
                        w_state_d = ST_DIME;
                        w_dime_d  = r_dime - CNT_W'(1);
                        w_load    = 1'b1;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
        if (bus.dispense && w_busy) w_err_d = 1'b1;
        if (!bus.dispense && (bus.ret_nickel || bus.ret_dime || bus.ret_two_dimes)) begin
            w_err_d = 1'b1;
        end
    end

    assign w_coin_lvl = {bus.coin_q, bus.coin_d, bus.coin_n};
    assign w_edge     = w_coin_lvl & ~r_coin_prev;
    assign w_multi    = (w_edge[0] & w_edge[1]) | (w_edge[0] & w_edge[2]) | (w_edge[1] & w_edge[2]);
    assign w_block    = w_multi | w_busy | bus.dispense;

    always_comb begin
        w_coin_d   = COIN_NONE;
        w_reject_d = (|w_edge) & w_block;
        if (!w_block) begin
            if (w_edge[0])      w_coin_d = COIN_NICKEL;
            else if (w_edge[1]) w_coin_d = COIN_DIME;
            else if (w_edge[2]) w_coin_d = COIN_QUARTER;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_nick      <= '0;
            r_dime      <= '0;
            r_err       <= 1'b0;
            r_coin_prev <= '0;
            r_coin      <= COIN_NONE;
            r_reject    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_nick      <= w_nick_d;
            r_dime      <= w_dime_d;
            r_err       <= w_err_d;
            r_coin_prev <= w_coin_lvl;
            r_coin      <= w_coin_d;
            r_reject    <= w_reject_d;
        end
    end

    assign bus.N             = (r_coin == COIN_NICKEL);
    assign bus.D             = (r_coin == COIN_DIME);
    assign bus.Q             = (r_coin == COIN_QUARTER);
    assign bus.coin_reject   = r_reject;
    assign bus.motor_en      = (r_state == ST_MOTOR);
    assign bus.hopper_nickel = (r_state == ST_NICKEL);
    assign bus.hopper_dime   = (r_state == ST_DIME);
    assign bus.busy          = w_busy;
    assign bus.coin_inhibit  = w_busy;
    assign bus.seq_err       = r_err;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with PULSE_CYCLES=4, GAP_CYCLES=2.
module tb_vend_sequencer;

    localparam int unsigned P = 4;
    localparam int unsigned G = 2;
    localparam int unsigned SLOT = P + G;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    vend_sequencer_if vif ();

    vend_sequencer #(
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] coins();
        return {vif.N, vif.D, vif.Q, vif.coin_reject};
    endfunction

    function automatic logic [2:0] acts();
        return {vif.motor_en, vif.hopper_nickel, vif.hopper_dime};
    endfunction

    function automatic logic [9:0] all_outs();
        return {coins(), vif.coin_inhibit, acts(), vif.busy, vif.seq_err};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("reset_outs", 32'(all_outs()), 32'h0);
    endtask

    // ph0..ph2 name the actuator per slot: 1 motor, 2 nickel, 3 dime.
    task automatic run_vend(input string tag, input logic n, input logic d, input logic two,
                            input int k, input int ph0, input int ph1, input int ph2,
                            input logic exp_err);
        int ph;
        logic [2:0] exp_act;
        vif.dispense      = 1'b1;
        vif.ret_nickel    = n;
        vif.ret_dime      = d;
        vif.ret_two_dimes = two;
        tick();
        vif.dispense      = 1'b0;
        vif.ret_nickel    = 1'b0;
        vif.ret_dime      = 1'b0;
        vif.ret_two_dimes = 1'b0;
        for (int i = 1; i <= k * int'(SLOT); i++) begin
            case ((i - 1) / int'(SLOT))
                0:       ph = ph0;
                1:       ph = ph1;
                default: ph = ph2;
            endcase
            if (((i - 1) % int'(SLOT)) < int'(P)) begin
                exp_act = (ph == 1) ? 3'b100 : (ph == 2) ? 3'b010 : 3'b001;
            end else begin
                exp_act = 3'b000;
            end
            check_eq({tag, "_act"}, 32'(acts()), 32'(exp_act));
            check_eq({tag, "_busy"}, 32'(vif.busy), 32'd1);
            check_eq({tag, "_inhibit"}, 32'(vif.coin_inhibit), 32'd1);
            tick();
        end
        check_eq({tag, "_busy_end"}, 32'(vif.busy), 32'd0);
        check_eq({tag, "_act_end"}, 32'(acts()), 32'd0);
        check_eq({tag, "_err"}, 32'(vif.seq_err), 32'(exp_err));
    endtask

    initial begin
        vif.coin_n        = 1'b0;
        vif.coin_d        = 1'b0;
        vif.coin_q        = 1'b0;
        vif.dispense      = 1'b0;
        vif.ret_nickel    = 1'b0;
        vif.ret_dime      = 1'b0;
        vif.ret_two_dimes = 1'b0;

        tick();
        check_eq("in_reset", 32'(all_outs()), 32'h0);
        rst = 1'b1;
        tick();
        check_eq("post_reset", 32'(all_outs()), 32'h0);

        // Dime held 3 cycles: one D pulse only.
        vif.coin_d = 1'b1;
        tick();
        check_eq("dime_pulse", 32'(coins()), 32'b0100);
        tick();
        check_eq("dime_hold1", 32'(coins()), 32'b0000);
        tick();
        vif.coin_d = 1'b0;
        check_eq("dime_hold2", 32'(coins()), 32'b0000);
        tick();
        check_eq("dime_after", 32'(coins()), 32'b0000);

        vif.coin_n = 1'b1;
        tick();
        check_eq("nickel_pulse", 32'(coins()), 32'b1000);
        vif.coin_n = 1'b0;
        tick();
        check_eq("nickel_after", 32'(coins()), 32'b0000);

        vif.coin_q = 1'b1;
        tick();
        check_eq("quarter_pulse", 32'(coins()), 32'b0010);
        vif.coin_q = 1'b0;
        tick();
        check_eq("quarter_after", 32'(coins()), 32'b0000);

        vif.coin_n = 1'b1;
        vif.coin_q = 1'b1;
        tick();
        check_eq("multi_reject", 32'(coins()), 32'b0001);
        tick();
        check_eq("multi_after", 32'(coins()), 32'b0000);
        vif.coin_n = 1'b0;
        vif.coin_q = 1'b0;
        tick();

        // Consecutive runs also exercise back-to-back dispense acceptance.
        run_vend("plain", 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 1'b0);
        run_vend("two_dimes", 1'b0, 1'b0, 1'b1, 3, 1, 3, 3, 1'b0);
        run_vend("nick_dime", 1'b1, 1'b1, 1'b0, 3, 1, 2, 3, 1'b0);

        // Coin on the dispense cycle, then again while busy.
        vif.dispense = 1'b1;
        vif.coin_q   = 1'b1;
        tick();
        vif.dispense = 1'b0;
        vif.coin_q   = 1'b0;
        check_eq("coin_at_dispense", 32'(coins()), 32'b0001);
        check_eq("busy_after_dispense", 32'(vif.busy), 32'd1);
        tick();
        vif.coin_n = 1'b1;
        tick();
        vif.coin_n = 1'b0;
        check_eq("coin_while_busy", 32'(coins()), 32'b0001);
        tick();
        tick();
        tick();
        check_eq("busy_last", 32'(vif.busy), 32'd1);
        tick();
        check_eq("busy_done", 32'(vif.busy), 32'd0);
        check_eq("coin_no_err", 32'(vif.seq_err), 32'd0);

        vif.ret_dime = 1'b1;
        tick();
        vif.ret_dime = 1'b0;
        check_eq("stray_err", 32'(vif.seq_err), 32'd1);
        check_eq("stray_ignored", 32'(vif.busy), 32'd0);
        tick();
        tick();
        check_eq("stray_sticky", 32'(vif.seq_err), 32'd1);

        do_reset();

        // Reset asserted while the dime hopper is running.
        vif.dispense = 1'b1;
        vif.ret_dime = 1'b1;
        tick();
        vif.dispense = 1'b0;
        vif.ret_dime = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        check_eq("mid_dime_on", 32'(acts()), 32'b001);
        rst = 1'b0;
        #2;
        check_eq("mid_async_outs", 32'(all_outs()), 32'h0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("mid_no_resume", 32'({acts(), vif.busy}), 32'h0);
        end

        // Second dispense (with a nickel request) during a vend is ignored.
        vif.dispense = 1'b1;
        tick();
        vif.ret_nickel = 1'b1;
        tick();
        vif.dispense   = 1'b0;
        vif.ret_nickel = 1'b0;
        check_eq("busy_dispense_err", 32'(vif.seq_err), 32'd1);
        for (int i = 2; i < 6; i++) tick();
        check_eq("busy_dispense_last", 32'({acts(), vif.busy}), 32'b0001);
        tick();
        check_eq("busy_dispense_end", 32'({acts(), vif.busy}), 32'b0000);

        do_reset();
        run_vend("both_dimes", 1'b0, 1'b1, 1'b1, 3, 1, 3, 3, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
